spi_slave_responder: RTL and testbench
======================================

SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

Interface
REQ-001 The block SHALL have parameter CMD_READ, default 8'h0F, the command byte that selects a read frame; every other command byte is a write.
REQ-002 The block SHALL have parameter RD_DEFAULT, default 32'hDEAD_BEEF, the word shifted out when read data is not returned in time.
REQ-003 The block SHALL have port mclk, input, 1 bit, the system clock; all logic runs on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset: synchronous, active-low.
REQ-005 The block SHALL have port sclk, input, 1 bit, the SPI clock; it is asynchronous to mclk and idles low.
REQ-006 The block SHALL have port cs_n, input, 1 bit, the active-low SPI chip select; it is asynchronous to mclk.
REQ-007 The block SHALL have port mosi, input, 1 bit, the master-to-slave serial data, MSB first.
REQ-008 The block SHALL have port miso, output, 1 bit, the slave-to-master serial data, MSB first.
REQ-009 The block SHALL have port miso_oe, output, 1 bit, the MISO output enable; it is high only while in state RDATA.
REQ-010 The block SHALL have ports wr_en (output, 1 bit), wr_addr (output, 16 bits) and wr_data (output, 32 bits), the register write strobe, address and data.
REQ-011 The block SHALL have ports rd_req (output, 1 bit) and rd_addr (output, 16 bits), the register read request and address.
REQ-012 The block SHALL have ports rd_valid (input, 1 bit) and rd_data (input, 32 bits), the register read return.
REQ-013 The block SHALL have ports busy (output, 1 bit) and frame_abort (output, 1 bit), the frame-in-progress flag and the abort pulse.
REQ-014 The block SHALL have port err_cnt, output, 8 bits, the abort counter (see Configuration).

Function
REQ-015 sclk, cs_n and mosi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized sclk.
REQ-016 The block SHALL require each sclk high phase and each sclk low phase to last at least 4 mclk cycles.
REQ-017 The frame SHALL be 8 command bits, then 16 address bits, then 32 data bits, all MSB first, with mosi sampled on each sclk rising edge.
REQ-018 The FSM SHALL have states IDLE, CMD, ADDR, WDATA, RDATA and WAIT_CS, with a 6-bit bit counter.
REQ-019 IDLE -> CMD SHALL occur on the synchronized falling edge of cs_n; busy SHALL be 1 in every state except IDLE.
REQ-020 CMD -> ADDR SHALL occur after the 8th sampled bit.
REQ-021 ADDR -> RDATA SHALL occur after the 24th bit when the command equals CMD_READ; otherwise ADDR -> WDATA.
REQ-022 On entry to RDATA, rd_req SHALL pulse for exactly one mclk cycle, with rd_addr holding the received address.
REQ-023 If rd_valid is seen before the first sclk falling edge in RDATA, rd_data SHALL be loaded into the TX shift register; otherwise RD_DEFAULT SHALL be loaded.
REQ-024 rd_valid arriving after that falling edge SHALL be ignored.
REQ-025 In RDATA, miso SHALL present the TX MSB from the first sclk falling edge and shift one bit per later falling edge, for 32 bits.
REQ-026 After the 32nd RDATA rising edge, the FSM SHALL go to WAIT_CS.
REQ-027 In WDATA, after the 56th bit is sampled, wr_en SHALL pulse for one mclk cycle within 2 mclk cycles, with wr_addr and wr_data stable from that pulse until the next wr_en; the FSM SHALL then go to WAIT_CS.
REQ-028 When not in RDATA, miso SHALL be 1.
REQ-029 In WAIT_CS, extra sclk edges SHALL be ignored; a synchronized cs_n rise SHALL return the FSM to IDLE.
REQ-030 A synchronized cs_n rise in CMD, ADDR, WDATA or RDATA SHALL return the FSM to IDLE and pulse frame_abort for one cycle, with no wr_en.
REQ-031 When a cs_n rise and an sclk edge are detected in the same cycle, the cs_n rise SHALL take priority.

Reset
REQ-032 While rst_n is low at an mclk edge, the FSM SHALL go to IDLE, the counters and shift registers SHALL clear, and the synchronizers SHALL load 1 for cs_n and 0 for sclk and mosi.
REQ-033 During reset, the outputs SHALL be: miso=1, miso_oe=0, wr_en=0, rd_req=0, frame_abort=0, busy=0, wr_addr=0, wr_data=0, rd_addr=0, err_cnt=0.
REQ-034 After reset is released while cs_n is low, the block SHALL wait for cs_n high before accepting any new frame; the partial frame SHALL NOT be flagged as an abort.

Configuration
REQ-035 With macro SPI_SLAVE_ERR_CNT_EN defined, err_cnt SHALL increment on each frame_abort pulse and saturate at 8'hFF.
REQ-036 Without SPI_SLAVE_ERR_CNT_EN, err_cnt SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-037 Write frame cmd 8'h01, addr 16'h0010, data 32'h1234_5678 -> exactly one wr_en pulse with wr_addr=16'h0010 and wr_data=32'h1234_5678; no rd_req.
REQ-038 Read frame cmd 8'h0F, addr 16'h0020, with rd_valid returning 32'hA5A5_0F0F 2 cycles after rd_req -> rd_addr=16'h0020, and the master captures 32'hA5A5_0F0F.
REQ-039 Read frame with rd_valid never asserted -> the master captures 32'hDEAD_BEEF.
REQ-040 cs_n raised after 40 bits of a write frame -> no wr_en, one frame_abort pulse, and err_cnt=1 when SPI_SLAVE_ERR_CNT_EN is defined.
REQ-041 rst_n pulsed low at bit 30, then a full write frame of data 32'h0000_00FF -> the first frame produces no output, and the second produces one correct wr_en.

Source files
------------

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI slave that turns 56-bit frames (8-bit command,
// 16-bit address, 32-bit data) into register write strobes or read requests.
// sclk/cs_n/mosi are oversampled on mclk through 2-flop synchronizers.
// Optional feature: define SPI_SLAVE_ERR_CNT_EN to build a saturating
// abort counter on err_cnt; otherwise err_cnt is tied to zero.
`timescale 1ns/1ps

module spi_slave_responder #(
    parameter logic [7:0]  CMD_READ   = 8'h0F,
    parameter logic [31:0] RD_DEFAULT = 32'hDEAD_BEEF
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic        rd_valid,
    input  logic [31:0] rd_data,
    output logic        busy,
    output logic        frame_abort,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDATA,
        WAIT_CS
    } state_t;

    // synchronizer and edge-history flops
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    // frame-start qualification after reset
    logic [1:0] settle_q;
    logic       armed_q;

    // FSM and datapath
    state_t      state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [30:0] rx_q, rx_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] tx_q, tx_d;
    logic        tx_loaded_q, tx_loaded_d;
    logic        first_fall_q, first_fall_d;
    logic        miso_q, miso_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        rd_req_q, rd_req_d;
    logic [15:0] rd_addr_q, rd_addr_d;
    logic        abort_q, abort_d;

    logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [31:0] rx_word;
    logic [31:0] load_word;
    logic [5:0]  bit_cnt_inc;

    assign sclk_rise   = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_sync_q & sclk_prev_q;
    assign cs_rise     = cs_sync_q & ~cs_prev_q;
    assign cs_fall     = ~cs_sync_q & cs_prev_q;
    // rx_word is the shift register including the bit being sampled now
    assign rx_word     = {rx_q, mosi_sync_q};
    assign bit_cnt_inc = bit_cnt_q + 6'd1;
    // word presented on the first RDATA falling edge; a return in that same
    // cycle still counts as in time
    assign load_word   = tx_loaded_q ? tx_q : (rd_valid ? rd_data : RD_DEFAULT);

    // Bring the asynchronous SPI pins into the mclk domain and keep one
    // cycle of history for edge detection.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= cs_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    // Arm frame acceptance only once the synchronizers hold real pin values
    // and cs_n has been seen high, so a frame cut by reset is never resumed.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
            if (settle_q == 2'd3 && cs_sync_q && cs_prev_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            rx_q         <= '0;
            cmd_q        <= '0;
            addr_q       <= '0;
            tx_q         <= '0;
            tx_loaded_q  <= 1'b0;
            first_fall_q <= 1'b0;
            miso_q       <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            tx_q         <= tx_d;
            tx_loaded_q  <= tx_loaded_d;
            first_fall_q <= first_fall_d;
            miso_q       <= miso_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            abort_q      <= abort_d;
        end
    end

    // Next-state and datapath logic; a cs_n rise always wins over an sclk edge.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        tx_d         = tx_q;
        tx_loaded_d  = tx_loaded_q;
        first_fall_d = first_fall_q;
        miso_d       = miso_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_req_d     = 1'b0;
        rd_addr_d    = rd_addr_q;
        abort_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                end
            end

            CMD: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (sclk_rise) begin
                    rx_d      = rx_word[30:0];
                    bit_cnt_d = bit_cnt_inc;
                    if (bit_cnt_q == 6'd7) begin
                        cmd_d   = rx_word[7:0];
                        state_d = ADDR;
                    end
                end
            end

            ADDR: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (sclk_rise) begin
                    rx_d      = rx_word[30:0];
                    bit_cnt_d = bit_cnt_inc;
                    if (bit_cnt_q == 6'd23) begin
                        addr_d = rx_word[15:0];
                        if (cmd_q == CMD_READ) begin
                            state_d      = RDATA;
                            rd_req_d     = 1'b1;
                            rd_addr_d    = rx_word[15:0];
                            tx_loaded_d  = 1'b0;
                            first_fall_d = 1'b0;
                            miso_d       = 1'b1;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
            end

            WDATA: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (sclk_rise) begin
                    rx_d      = rx_word[30:0];
                    bit_cnt_d = bit_cnt_inc;
                    if (bit_cnt_q == 6'd55) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = rx_word;
                        state_d   = WAIT_CS;
                    end
                end
            end

            RDATA: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else begin
                    // capture an early read return; ignored once shifting began
                    if (!first_fall_q && !tx_loaded_q && rd_valid) begin
                        tx_d        = rd_data;
                        tx_loaded_d = 1'b1;
                    end
                    if (sclk_fall) begin
                        if (!first_fall_q) begin
                            miso_d       = load_word[31];
                            tx_d         = {load_word[30:0], 1'b0};
                            first_fall_d = 1'b1;
                        end else begin
                            miso_d = tx_q[31];
                            tx_d   = {tx_q[30:0], 1'b0};
                        end
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_inc;
                        if (bit_cnt_q == 6'd55) begin
                            state_d = WAIT_CS;
                        end
                    end
                end
            end

            WAIT_CS: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign miso_oe     = (state_q == RDATA);
    assign miso        = (state_q == RDATA) ? miso_q : 1'b1;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_req      = rd_req_q;
    assign rd_addr     = rd_addr_q;
    assign frame_abort = abort_q;

`ifdef SPI_SLAVE_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Count aborted frames, saturating at all-ones.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else if (abort_q && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_spi_slave_responder.sv
// Testbench for spi_slave_responder: drives directed SPI frames as a master
// and checks DUT outputs against a transaction-level expectation model.
`timescale 1ns/1ps

module tb_spi_slave_responder;

    localparam int T  = 10;   // mclk period
    localparam int HP = 80;   // sclk half period (8 mclk cycles)

    logic        mclk = 1'b0;
    logic        rst_n, sclk, cs_n, mosi;
    logic        miso, miso_oe, wr_en, rd_req, rd_valid, busy, frame_abort;
    logic [15:0] wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;
    logic [7:0]  err_cnt;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_wr_q[$];
    logic [15:0] exp_rd_q[$];
    wr_t         mon_e;

    int n_checks   = 0;
    int n_pass     = 0;
    int wr_seen    = 0;
    int rd_seen    = 0;
    int abort_seen = 0;
    int exp_abort  = 0;
    int exp_err    = 0;
    int rd_delay   = -1;
    logic [31:0] rd_resp = 32'h0;
    logic [31:0] cap;
    logic        abort_prev = 1'b0;

    spi_slave_responder dut (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy),
        .frame_abort (frame_abort),
        .err_cnt     (err_cnt)
    );

    initial forever #(T/2) mclk = ~mclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Per-cycle compare against the expectation queues and invariants.
    initial forever begin
        @(negedge mclk);
        if (rst_n) begin
            if (!miso_oe) check("miso_idle_high", {63'b0, miso}, 64'd1);
            else          check("miso_oe_implies_busy", {63'b0, busy}, 64'd1);
            if (wr_en) begin
                wr_seen++;
                if (exp_wr_q.size() == 0) begin
                    check("wr_en_unexpected", {63'b0, wr_en}, 64'd0);
                end else begin
                    mon_e = exp_wr_q.pop_front();
                    check("wr_addr", {48'b0, wr_addr}, {48'b0, mon_e.a});
                    check("wr_data", {32'b0, wr_data}, {32'b0, mon_e.d});
                end
            end
            if (rd_req) begin
                rd_seen++;
                if (exp_rd_q.size() == 0) check("rd_req_unexpected", {63'b0, rd_req}, 64'd0);
                else check("rd_addr", {48'b0, rd_addr}, {48'b0, exp_rd_q.pop_front()});
            end
            if (frame_abort) begin
                abort_seen++;
                if (abort_prev) check("abort_single_cycle", {63'b0, frame_abort}, 64'd0);
            end
            abort_prev = frame_abort;
        end
    end

    // Register-read responder: returns rd_resp rd_delay cycles after rd_req.
    initial begin
        rd_valid = 1'b0;
        rd_data  = 32'h0;
        forever begin
            @(negedge mclk);
            if (rst_n && rd_req && rd_delay >= 0) begin
                repeat (rd_delay) @(posedge mclk);
                #1;
                rd_valid = 1'b1;
                rd_data  = rd_resp;
                @(posedge mclk);
                #1;
                rd_valid = 1'b0;
                rd_data  = 32'h0;
            end
        end
    end

    // SPI master (mode 0). rst_bit >= 0 pulses rst_n during that bit's high phase.
    task automatic spi_xfer(input logic [7:0] cmd, input logic [15:0] addr,
                            input logic [31:0] data, input int nbits,
                            input int rst_bit, output logic [31:0] captured);
        logic [55:0] frame;
        frame    = {cmd, addr, data};
        captured = 32'h0;
        cs_n = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            mosi = (b < 56) ? frame[55-b] : 1'b0;
            #(HP);
            if (b == 0) check("busy_in_frame", {63'b0, busy}, 64'd1);
            if (b == 40 && cmd == 8'h0F) check("miso_oe_rdata", {63'b0, miso_oe}, 64'd1);
            if (b >= 24 && b < 56) captured = {captured[30:0], miso};
            sclk = 1'b1;
            if (b == rst_bit) begin
                rst_n = 1'b0;
                exp_err = 0;
                #(3*T);
                rst_n = 1'b1;
                #(T);
                check("busy_after_rst", {63'b0, busy}, 64'd0);
                #(HP - 4*T);
            end else begin
                #(HP);
            end
            sclk = 1'b0;
        end
        #(HP);
        cs_n = 1'b1;
        #(4*HP);
    endtask

    // End-of-frame bookkeeping against the model.
    task automatic frame_done(input string tag, input int wr0, input int wr_exp,
                              input int rd0, input int rd_exp);
        int err_model;
        err_model = exp_err;
`ifndef SPI_SLAVE_ERR_CNT_EN
        err_model = 0;
`endif
        check({tag, "_wr_count"}, 64'(wr_seen - wr0), 64'(wr_exp));
        check({tag, "_rd_count"}, 64'(rd_seen - rd0), 64'(rd_exp));
        check({tag, "_wr_queue_drained"}, 64'(exp_wr_q.size()), 64'd0);
        check({tag, "_abort_count"}, 64'(abort_seen), 64'(exp_abort));
        check({tag, "_err_cnt"}, {56'b0, err_cnt}, 64'(err_model));
        check({tag, "_busy_idle"}, {63'b0, busy}, 64'd0);
        $display("frame %s: wr=%0d rd=%0d aborts=%0d err_cnt=%0d", tag,
                 wr_seen - wr0, rd_seen - rd0, abort_seen, err_cnt);
    endtask

    initial begin
        int wr0, rd0;
        rst_n = 1'b0;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        repeat (4) @(posedge mclk);
        #3;
        check("rst_miso",     {63'b0, miso},        64'd1);
        check("rst_miso_oe",  {63'b0, miso_oe},     64'd0);
        check("rst_wr_en",    {63'b0, wr_en},       64'd0);
        check("rst_rd_req",   {63'b0, rd_req},      64'd0);
        check("rst_abort",    {63'b0, frame_abort}, 64'd0);
        check("rst_busy",     {63'b0, busy},        64'd0);
        check("rst_wr_addr",  {48'b0, wr_addr},     64'd0);
        check("rst_wr_data",  {32'b0, wr_data},     64'd0);
        check("rst_rd_addr",  {48'b0, rd_addr},     64'd0);
        check("rst_err_cnt",  {56'b0, err_cnt},     64'd0);
        $display("reset: outputs checked");
        rst_n = 1'b1;
        #(10*T);

        // plain write
        wr0 = wr_seen; rd0 = rd_seen;
        exp_wr_q.push_back('{a: 16'h0010, d: 32'h1234_5678});
        spi_xfer(8'h01, 16'h0010, 32'h1234_5678, 56, -1, cap);
        frame_done("write1", wr0, 1, rd0, 0);
        check("write1_wr_addr_literal", {48'b0, wr_addr}, 64'h0010);
        check("write1_wr_data_literal", {32'b0, wr_data}, 64'h1234_5678);

        // read with timely return
        wr0 = wr_seen; rd0 = rd_seen;
        rd_delay = 2; rd_resp = 32'hA5A5_0F0F;
        exp_rd_q.push_back(16'h0020);
        spi_xfer(8'h0F, 16'h0020, 32'h0, 56, -1, cap);
        frame_done("read_ok", wr0, 0, rd0, 1);
        check("read_ok_rd_addr_literal", {48'b0, rd_addr}, 64'h0020);
        check("read_ok_captured", {32'b0, cap}, 64'hA5A5_0F0F);

        // read with no return
        wr0 = wr_seen; rd0 = rd_seen;
        rd_delay = -1;
        exp_rd_q.push_back(16'h0030);
        spi_xfer(8'h0F, 16'h0030, 32'h0, 56, -1, cap);
        frame_done("read_none", wr0, 0, rd0, 1);
        check("read_none_captured", {32'b0, cap}, 64'hDEAD_BEEF);

        // read whose return arrives after the first falling edge
        wr0 = wr_seen; rd0 = rd_seen;
        rd_delay = 30; rd_resp = 32'h1357_9BDF;
        exp_rd_q.push_back(16'h0040);
        spi_xfer(8'h0F, 16'h0040, 32'h0, 56, -1, cap);
        frame_done("read_late", wr0, 0, rd0, 1);
        check("read_late_captured", {32'b0, cap}, 64'hDEAD_BEEF);
        rd_delay = -1;

        // write with extra sclk pulses after bit 56
        wr0 = wr_seen; rd0 = rd_seen;
        exp_wr_q.push_back('{a: 16'hABCD, d: 32'hCAFE_F00D});
        spi_xfer(8'h0E, 16'hABCD, 32'hCAFE_F00D, 60, -1, cap);
        frame_done("write_extra", wr0, 1, rd0, 0);

        // aborted write after 40 bits
        wr0 = wr_seen; rd0 = rd_seen;
        exp_abort++;
        if (exp_err < 255) exp_err++;
        spi_xfer(8'h01, 16'h0050, 32'h55AA_55AA, 40, -1, cap);
        frame_done("abort40", wr0, 0, rd0, 0);

        // reset during bit 30, frame then completes without effect
        wr0 = wr_seen; rd0 = rd_seen;
        spi_xfer(8'h01, 16'h0060, 32'h8765_4321, 56, 30, cap);
        frame_done("rst_mid", wr0, 0, rd0, 0);

        // following full write
        wr0 = wr_seen; rd0 = rd_seen;
        exp_wr_q.push_back('{a: 16'h0070, d: 32'h0000_00FF});
        spi_xfer(8'h01, 16'h0070, 32'h0000_00FF, 56, -1, cap);
        frame_done("write_after_rst", wr0, 1, rd0, 0);
        check("write_after_rst_data_literal", {32'b0, wr_data}, 64'h0000_00FF);
        check("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
